// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: states, opcodes,
// ALU operation classes and datapath mux selects, plus the decoded control word.
package multicycle_control_pkg;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_R_EXEC    = 4'd2;
    localparam logic [3:0] ST_R_WB      = 4'd3;
    localparam logic [3:0] ST_I_EXEC    = 4'd4;
    localparam logic [3:0] ST_I_WB      = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd6;
    localparam logic [3:0] ST_MEM_READ  = 4'd7;
    localparam logic [3:0] ST_MEM_WB    = 4'd8;
    localparam logic [3:0] ST_MEM_WRITE = 4'd9;
    localparam logic [3:0] ST_BRANCH    = 4'd10;
    localparam logic [3:0] ST_JUMP      = 4'd11;
    localparam logic [3:0] ST_HALT      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation classes, decoded further by the ALU control unit
    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       zero_ext;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the main control FSM and the datapath: opcode/memory handshake
// in, control strobes, mux selects and status out.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       zero_ext;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport slave (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, zero_ext, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, mem_timeout, state_o
    );

    modport master (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, zero_ext, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, mem_timeout, state_o
    );

endinterface

// File: rtl/multicycle_control_outputs.sv
// Pure decoder from FSM state (plus opcode and the fetch handshake) to the
// datapath control word.
module multicycle_control_outputs
    import multicycle_control_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    logic w_is_ori;
    assign w_is_ori = (i_opcode == OP_ORI);

    // Control word per state; anything not listed stays deasserted.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            ST_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = w_is_ori ? ALU_OR : ALU_ADD;
                o_ctrl.zero_ext  = w_is_ori;
            end
            ST_I_WB: begin
                o_ctrl.reg_dst   = 1'b0;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.zero_ext  = w_is_ori;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_READ: begin
                o_ctrl.i_or_d   = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WRITE: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.branch_ne     = (i_opcode == OP_BNE);
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic, memory wait counter with timeout, and sticky error flags.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);

    localparam bit              TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_waiting;
    logic             w_expire;
    ctrl_t            w_ctrl;

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                       (r_state == ST_MEM_WRITE);
    // Timeout fires on the last allowed wait cycle; a same-cycle mem_ready wins.
    assign w_expire  = TO_EN && w_waiting && !bus.mem_ready && (r_cnt == CNT_LAST);

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (bus.mem_ready)   w_next = ST_DECODE;
                else if (w_expire)   w_next = ST_HALT;
                else                 w_next = ST_FETCH;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:        w_next = ST_R_EXEC;
                    OP_ADDI, OP_ORI: w_next = ST_I_EXEC;
                    OP_LW, OP_SW:    w_next = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:  w_next = ST_BRANCH;
                    OP_J:            w_next = ST_JUMP;
                    default:         w_next = ST_HALT;
                endcase
            end
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB:     w_next = ST_FETCH;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB:     w_next = ST_FETCH;
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LW) w_next = ST_MEM_READ;
                else                     w_next = ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                if (bus.mem_ready)   w_next = ST_MEM_WB;
                else if (w_expire)   w_next = ST_HALT;
                else                 w_next = ST_MEM_READ;
            end
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WRITE: begin
                if (bus.mem_ready)   w_next = ST_FETCH;
                else if (w_expire)   w_next = ST_HALT;
                else                 w_next = ST_MEM_WRITE;
            end
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    // Wait counter: cleared on any state change, so it starts at zero in every waiting state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          r_cnt <= '0;
        else if (w_next != r_state)          r_cnt <= '0;
        else if (w_waiting && !bus.mem_ready) r_cnt <= r_cnt + CNT_W'(1);
        else                                 r_cnt <= r_cnt;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_DECODE) && (w_next == ST_HALT)) r_illegal <= 1'b1;
            else                                               r_illegal <= r_illegal;
            if (w_expire) r_timeout <= 1'b1;
            else          r_timeout <= r_timeout;
        end
    end

    multicycle_control_outputs u_outputs (
        .i_state     (r_state),
        .i_opcode    (bus.opcode),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.pc_write_cond = w_ctrl.pc_write_cond;
    assign bus.branch_ne     = w_ctrl.branch_ne;
    assign bus.i_or_d        = w_ctrl.i_or_d;
    assign bus.mem_read      = w_ctrl.mem_read;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.ir_write      = w_ctrl.ir_write;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.zero_ext      = w_ctrl.zero_ext;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_src_b     = w_ctrl.alu_src_b;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.pc_source     = w_ctrl.pc_source;
    assign bus.illegal_op    = r_illegal;
    assign bus.mem_timeout   = r_timeout;
    assign bus.state_o       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model pushes the
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic [3:0]  st;
        logic        ill;
        logic        tmo;
        logic [18:0] w;
    } exp_t;

    logic clk;
    logic reset;
    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  q_exp[$];
    string q_tag[$];
    int    checks   = 0;
    int    failures = 0;
    logic  m_ill, m_to;

    logic [18:0] W_FETCH0, W_FETCH1, W_DEC, W_REX, W_RWB, W_IEX_ADD, W_IEX_OR;
    logic [18:0] W_IWB_ADD, W_IWB_OR, W_MADDR, W_MRD, W_MWB, W_MWR, W_BEQ, W_BNE, W_JMP, W_HALT;

    function automatic logic [18:0] mk(input logic pcw, input logic pcwc, input logic bne,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rdst,
                                       input logic rw, input logic zx, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] aop,
                                       input logic [1:0] psrc);
        return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rdst, rw, zx, asa, asb, aop, psrc};
    endfunction

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string t;
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            a.st  = bus.state_o;
            a.ill = bus.illegal_op;
            a.tmo = bus.mem_timeout;
            a.w   = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                     bus.zero_ext, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s @%0t: got st=%0d ill=%b tmo=%b ctrl=%b, want st=%0d ill=%b tmo=%b ctrl=%b",
                         t, $time, a.st, a.ill, a.tmo, a.w, e.st, e.ill, e.tmo, e.w);
            end
        end
    end

    task automatic cyc(input logic [3:0] st, input logic [18:0] w, input string tag, input logic rdy);
        exp_t e;
        bus.mem_ready = rdy;
        e.st = st; e.ill = m_ill; e.tmo = m_to; e.w = w;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        exp_t e;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        m_ill = 1'b0;
        m_to  = 1'b0;
        e.st = ST_FETCH; e.ill = 1'b0; e.tmo = 1'b0; e.w = W_FETCH0;
        q_exp.push_back(e);
        q_tag.push_back("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Memory access of n wait cycles; n >= TO exhausts the timeout and halts.
    task automatic mem_phase(input logic [3:0] st, input logic [18:0] w_wait,
                             input logic [18:0] w_go, input int n, input string tag,
                             output bit halted);
        halted = 1'b0;
        for (int i = 0; i < n && i < TO; i++) cyc(st, w_wait, tag, 1'b0);
        if (n >= TO) begin
            m_to = 1'b1;
            repeat (2) cyc(ST_HALT, W_HALT, "halt_timeout", rnd_bit());
            halted = 1'b1;
        end else begin
            cyc(st, w_go, tag, 1'b1);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit halted;
        bus.opcode = op;
        mem_phase(ST_FETCH, W_FETCH0, W_FETCH1, fw, "fetch", halted);
        if (!halted) begin
            cyc(ST_DECODE, W_DEC, "decode", rnd_bit());
            case (op)
                OP_RTYPE: begin
                    cyc(ST_R_EXEC, W_REX, "r_exec", rnd_bit());
                    cyc(ST_R_WB, W_RWB, "r_wb", rnd_bit());
                end
                OP_ADDI: begin
                    cyc(ST_I_EXEC, W_IEX_ADD, "addi_exec", rnd_bit());
                    cyc(ST_I_WB, W_IWB_ADD, "addi_wb", rnd_bit());
                end
                OP_ORI: begin
                    cyc(ST_I_EXEC, W_IEX_OR, "ori_exec", rnd_bit());
                    cyc(ST_I_WB, W_IWB_OR, "ori_wb", rnd_bit());
                end
                OP_LW: begin
                    cyc(ST_MEM_ADDR, W_MADDR, "lw_addr", rnd_bit());
                    mem_phase(ST_MEM_READ, W_MRD, W_MRD, mw, "lw_read", halted);
                    if (!halted) cyc(ST_MEM_WB, W_MWB, "lw_wb", rnd_bit());
                end
                OP_SW: begin
                    cyc(ST_MEM_ADDR, W_MADDR, "sw_addr", rnd_bit());
                    mem_phase(ST_MEM_WRITE, W_MWR, W_MWR, mw, "sw_write", halted);
                end
                OP_BEQ: cyc(ST_BRANCH, W_BEQ, "beq", rnd_bit());
                OP_BNE: cyc(ST_BRANCH, W_BNE, "bne", rnd_bit());
                OP_J:   cyc(ST_JUMP, W_JMP, "jump", rnd_bit());
                default: begin
                    m_ill = 1'b1;
                    repeat (3) cyc(ST_HALT, W_HALT, "halt_illegal", rnd_bit());
                    halted = 1'b1;
                end
            endcase
        end
        if (halted) do_reset();
    endtask

    logic [5:0] legal_ops[8];

    initial begin
        //              pcw  pcwc bne  iord mr   mw   irw  m2r  rdst rw   zx   asa  asb    aop     psrc
        W_FETCH0  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b100,2'b00);
        W_FETCH1  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b100,2'b00);
        W_DEC     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b100,2'b00);
        W_REX     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b111,2'b00);
        W_RWB     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00);
        W_IEX_ADD = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b100,2'b00);
        W_IEX_OR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,3'b101,2'b00);
        W_IWB_ADD = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00);
        W_IWB_OR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00);
        W_MADDR   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b100,2'b00);
        W_MRD     = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00);
        W_MWB     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00);
        W_MWR     = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00);
        W_BEQ     = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01);
        W_BNE     = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01);
        W_JMP     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10);
        W_HALT    = 19'd0;
        legal_ops = '{OP_RTYPE, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J};

        m_ill = 1'b0;
        m_to  = 1'b0;
        reset = 1'b0;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_ORI, 0, 0);
        run_instr(OP_ADDI, 1, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_J, 2, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_RTYPE, TO - 1, 0);
        run_instr(OP_RTYPE, TO, 0);
        run_instr(OP_LW, 0, TO - 1);
        run_instr(OP_SW, 0, TO);

        // Abort mid-MEM_READ: reset must land straight in FETCH with clean flags
        bus.opcode = OP_LW;
        cyc(ST_FETCH, W_FETCH1, "abort_fetch", 1'b1);
        cyc(ST_DECODE, W_DEC, "abort_decode", 1'b0);
        cyc(ST_MEM_ADDR, W_MADDR, "abort_addr", 1'b0);
        cyc(ST_MEM_READ, W_MRD, "abort_read", 1'b0);
        cyc(ST_MEM_READ, W_MRD, "abort_read", 1'b0);
        do_reset();
        run_instr(OP_ADDI, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            logic [5:0] op;
            int fw, mw;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else                          op = legal_ops[$urandom_range(0, 7)];
            fw = ($urandom_range(0, 24) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 14) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
            run_instr(op, fw, mw);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
